// File: rtl/id_fwd_stage.sv
// Decode-side operand stage: operand forwarding from EX/MEM, load-use interlock,
// registered ID/EX boundary with stall/flush control and a saturating bubble counter.
module id_fwd_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int OP_W     = 3,
    parameter int CNT_W    = 8,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid_i,
    input  logic              dec_re0_i,
    input  logic              dec_re1_i,
    input  logic [ADDR_W-1:0] dec_addr0_i,
    input  logic [ADDR_W-1:0] dec_addr1_i,
    input  logic              dec_imm_sel1_i,
    input  logic [DATA_W-1:0] dec_imm_i,
    input  logic [OP_W-1:0]   dec_aluop_i,
    input  logic [OP_W-1:0]   dec_alusel_i,
    input  logic              dec_we_i,
    input  logic [ADDR_W-1:0] dec_waddr_i,
    input  logic              dec_load_i,
    input  logic [DATA_W-1:0] rf_data0_i,
    input  logic [DATA_W-1:0] rf_data1_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic              we_o,
    output logic              load_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [OP_W-1:0]   aluop_o,
    output logic [OP_W-1:0]   alusel_o,
    output logic [DATA_W-1:0] op0_o,
    output logic [DATA_W-1:0] op1_o,
    output logic              stall_req_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              zero0, zero1;
    logic              ex_hit0, ex_hit1;
    logic              mem_hit0, mem_hit1;
    logic              reg_rd1;
    logic              haz0, haz1, hazard;
    logic [DATA_W-1:0] op0_sel, op1_sel;

    // Address 0 is hard-wired only when ZERO_REG is set; it is then never a forward or hazard source.
    assign zero0 = ZERO_REG && (dec_addr0_i == '0);
    assign zero1 = ZERO_REG && (dec_addr1_i == '0);

    assign ex_hit0  = valid_o & we_o & (waddr_o == dec_addr0_i);
    assign ex_hit1  = valid_o & we_o & (waddr_o == dec_addr1_i);
    assign mem_hit0 = mem_we_i & (mem_waddr_i == dec_addr0_i);
    assign mem_hit1 = mem_we_i & (mem_waddr_i == dec_addr1_i);

    assign reg_rd1 = dec_re1_i & ~dec_imm_sel1_i;

    always_comb begin
        op0_sel = rf_data0_i;
        if (!dec_re0_i || zero0) op0_sel = '0;
        else if (ex_hit0)        op0_sel = ex_wdata_i;
        else if (mem_hit0)       op0_sel = mem_wdata_i;
    end

    always_comb begin
        op1_sel = rf_data1_i;
        if (dec_imm_sel1_i)           op1_sel = dec_imm_i;
        else if (!dec_re1_i || zero1) op1_sel = '0;
        else if (ex_hit1)             op1_sel = ex_wdata_i;
        else if (mem_hit1)            op1_sel = mem_wdata_i;
    end

    assign haz0   = dec_re0_i & ~zero0 & (dec_addr0_i == waddr_o);
    assign haz1   = reg_rd1   & ~zero1 & (dec_addr1_i == waddr_o);
    assign hazard = dec_valid_i & valid_o & load_o & we_o & (haz0 | haz1);

    assign stall_req_o = hazard & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o      <= 1'b0;
            we_o         <= 1'b0;
            load_o       <= 1'b0;
            waddr_o      <= '0;
            aluop_o      <= '0;
            alusel_o     <= '0;
            op0_o        <= '0;
            op1_o        <= '0;
            bubble_cnt_o <= '0;
        end else if (flush_i || (!stall_i && hazard)) begin
            valid_o  <= 1'b0;
            we_o     <= 1'b0;
            load_o   <= 1'b0;
            waddr_o  <= '0;
            aluop_o  <= '0;
            alusel_o <= '0;
            op0_o    <= '0;
            op1_o    <= '0;
            // Only interlock bubbles are counted, never flushes.
            if (!flush_i && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end else if (!stall_i) begin
            valid_o  <= dec_valid_i;
            we_o     <= dec_we_i;
            load_o   <= dec_load_i;
            waddr_o  <= dec_waddr_i;
            aluop_o  <= dec_aluop_i;
            alusel_o <= dec_alusel_i;
            op0_o    <= op0_sel;
            op1_o    <= op1_sel;
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: two instances (defaults, and ZERO_REG=1 with a 2-bit counter)
// share one stimulus stream and are compared against a pipeline-record reference model.
module tb_id_fwd_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid_i, dec_re0_i, dec_re1_i, dec_imm_sel1_i, dec_we_i, dec_load_i;
    logic [3:0]  dec_addr0_i, dec_addr1_i, dec_waddr_i, mem_waddr_i;
    logic [15:0] dec_imm_i, rf_data0_i, rf_data1_i, ex_wdata_i, mem_wdata_i;
    logic [2:0]  dec_aluop_i, dec_alusel_i;
    logic        mem_we_i, stall_i, flush_i;

    logic        valid_o [2];
    logic        we_o    [2];
    logic        load_o  [2];
    logic [3:0]  waddr_o [2];
    logic [2:0]  aluop_o [2];
    logic [2:0]  alusel_o[2];
    logic [15:0] op0_o   [2];
    logic [15:0] op1_o   [2];
    logic        sreq_o  [2];
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_fwd_stage #(.ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid_i), .dec_re0_i(dec_re0_i), .dec_re1_i(dec_re1_i),
        .dec_addr0_i(dec_addr0_i), .dec_addr1_i(dec_addr1_i),
        .dec_imm_sel1_i(dec_imm_sel1_i), .dec_imm_i(dec_imm_i),
        .dec_aluop_i(dec_aluop_i), .dec_alusel_i(dec_alusel_i),
        .dec_we_i(dec_we_i), .dec_waddr_i(dec_waddr_i), .dec_load_i(dec_load_i),
        .rf_data0_i(rf_data0_i), .rf_data1_i(rf_data1_i), .ex_wdata_i(ex_wdata_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_o[0]), .we_o(we_o[0]), .load_o(load_o[0]), .waddr_o(waddr_o[0]),
        .aluop_o(aluop_o[0]), .alusel_o(alusel_o[0]), .op0_o(op0_o[0]), .op1_o(op1_o[0]),
        .stall_req_o(sreq_o[0]), .bubble_cnt_o(cnt_a)
    );

    id_fwd_stage #(.ZERO_REG(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid_i), .dec_re0_i(dec_re0_i), .dec_re1_i(dec_re1_i),
        .dec_addr0_i(dec_addr0_i), .dec_addr1_i(dec_addr1_i),
        .dec_imm_sel1_i(dec_imm_sel1_i), .dec_imm_i(dec_imm_i),
        .dec_aluop_i(dec_aluop_i), .dec_alusel_i(dec_alusel_i),
        .dec_we_i(dec_we_i), .dec_waddr_i(dec_waddr_i), .dec_load_i(dec_load_i),
        .rf_data0_i(rf_data0_i), .rf_data1_i(rf_data1_i), .ex_wdata_i(ex_wdata_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_o[1]), .we_o(we_o[1]), .load_o(load_o[1]), .waddr_o(waddr_o[1]),
        .aluop_o(aluop_o[1]), .alusel_o(alusel_o[1]), .op0_o(op0_o[1]), .op1_o(op1_o[1]),
        .stall_req_o(sreq_o[1]), .bubble_cnt_o(cnt_b)
    );

    // Reference: the instruction sitting in EX, as a record.
    typedef struct {
        bit        v, we, ld;
        bit [3:0]  wa;
        bit [2:0]  aop, asel;
        bit [15:0] o0, o1;
        int        cnt;
    } rec_t;

    rec_t m [2];
    bit   zr   [2] = '{1'b0, 1'b1};
    int   cmax [2] = '{255, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [15:0] pick(int k, bit en, bit [3:0] a, bit [15:0] rf);
        if (!en || (zr[k] && a == 0))              return 16'h0;
        if (m[k].v && m[k].we && m[k].wa == a)    return ex_wdata_i;
        if (mem_we_i && mem_waddr_i == a)         return mem_wdata_i;
        return rf;
    endfunction

    function automatic bit loaded_reg_read(int k, bit en, bit [3:0] a);
        return en && a == m[k].wa && !(zr[k] && a == 0);
    endfunction

    function automatic bit haz(int k);
        if (!(dec_valid_i && m[k].v && m[k].ld && m[k].we)) return 1'b0;
        return loaded_reg_read(k, dec_re0_i, dec_addr0_i) ||
               loaded_reg_read(k, dec_re1_i && !dec_imm_sel1_i, dec_addr1_i);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) m[k] = '{default: 0};
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 2; k++) begin
            string t;
            t = $sformatf("%s/%0d", tag, k);
            check({t, ".valid"}, valid_o[k], m[k].v);
            check({t, ".we"},    we_o[k],    m[k].we);
            check({t, ".load"},  load_o[k],  m[k].ld);
            check({t, ".waddr"}, waddr_o[k], m[k].wa);
            check({t, ".aluop"}, aluop_o[k], m[k].aop);
            check({t, ".alusel"},alusel_o[k],m[k].asel);
            check({t, ".op0"},   op0_o[k],   m[k].o0);
            check({t, ".op1"},   op1_o[k],   m[k].o1);
        end
        check({tag, "/0.cnt"}, cnt_a, m[0].cnt);
        check({tag, "/1.cnt"}, cnt_b, m[1].cnt);
    endtask

    // Inputs must already be applied; checks the interlock, clocks once, checks the new record.
    task automatic step(input string tag);
        rec_t nx [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit h;
            h = haz(k);
            check($sformatf("%s/%0d.stall_req", tag, k), sreq_o[k], h && !flush_i);
            nx[k] = m[k];
            if (flush_i || (!stall_i && h)) begin
                nx[k] = '{default: 0};
                nx[k].cnt = m[k].cnt;
                if (!flush_i && m[k].cnt < cmax[k]) nx[k].cnt = m[k].cnt + 1;
            end else if (!stall_i) begin
                nx[k].v    = dec_valid_i;
                nx[k].we   = dec_we_i;
                nx[k].ld   = dec_load_i;
                nx[k].wa   = dec_waddr_i;
                nx[k].aop  = dec_aluop_i;
                nx[k].asel = dec_alusel_i;
                nx[k].o0   = pick(k, dec_re0_i, dec_addr0_i, rf_data0_i);
                nx[k].o1   = dec_imm_sel1_i ? dec_imm_i
                                            : pick(k, dec_re1_i, dec_addr1_i, rf_data1_i);
            end
        end
        @(posedge clk);
        #1;
        m = nx;
        check_outs(tag);
    endtask

    task automatic clr_in();
        {dec_valid_i, dec_re0_i, dec_re1_i, dec_imm_sel1_i, dec_we_i, dec_load_i} = '0;
        {dec_addr0_i, dec_addr1_i, dec_waddr_i, mem_waddr_i} = '0;
        {dec_imm_i, rf_data0_i, rf_data1_i, ex_wdata_i, mem_wdata_i} = '0;
        {dec_aluop_i, dec_alusel_i, mem_we_i, stall_i, flush_i} = '0;
    endtask

    task automatic rand_in(input bit addr_small);
        dec_valid_i    = $urandom_range(0, 3) != 0;
        dec_re0_i      = $urandom_range(0, 1);
        dec_re1_i      = $urandom_range(0, 1);
        dec_imm_sel1_i = $urandom_range(0, 3) == 0;
        dec_we_i       = $urandom_range(0, 1);
        dec_load_i     = $urandom_range(0, 2) == 0;
        dec_addr0_i    = addr_small ? 4'($urandom_range(0, 3)) : 4'($urandom);
        dec_addr1_i    = addr_small ? 4'($urandom_range(0, 3)) : 4'($urandom);
        dec_waddr_i    = addr_small ? 4'($urandom_range(0, 3)) : 4'($urandom);
        mem_waddr_i    = addr_small ? 4'($urandom_range(0, 3)) : 4'($urandom);
        mem_we_i       = $urandom_range(0, 1);
        dec_imm_i      = 16'($urandom);
        rf_data0_i     = 16'($urandom);
        rf_data1_i     = 16'($urandom);
        ex_wdata_i     = 16'($urandom);
        mem_wdata_i    = 16'($urandom);
        dec_aluop_i    = 3'($urandom);
        dec_alusel_i   = 3'($urandom);
        stall_i        = $urandom_range(0, 7) == 0;
        flush_i        = $urandom_range(0, 9) == 0;
    endtask

    task automatic issue_load(input bit [3:0] r);
        clr_in();
        dec_valid_i = 1; dec_we_i = 1; dec_load_i = 1; dec_waddr_i = r;
    endtask

    initial begin
        // Reset held with random inputs, including clock edges.
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b0);
            @(posedge clk);
            #1;
        end
        check_outs("reset");
        check("reset/0.stall_req", sreq_o[0], 1'b0);
        check("reset/1.stall_req", sreq_o[1], 1'b0);
        clr_in();
        rst = 1'b1;

        // First capture.
        dec_valid_i = 1; dec_re0_i = 1; dec_addr0_i = 4'd2; rf_data0_i = 16'h0001;
        step("first");
        check("first.op0", op0_o[0], 16'h0001);
        check("first.valid", valid_o[0], 1'b1);

        // EX beats MEM on the same address.
        clr_in();
        dec_valid_i = 1; dec_we_i = 1; dec_waddr_i = 4'd3;
        step("exfwd_a");
        clr_in();
        dec_valid_i = 1; dec_re0_i = 1; dec_addr0_i = 4'd3; ex_wdata_i = 16'h00AA;
        mem_we_i = 1; mem_waddr_i = 4'd3; mem_wdata_i = 16'h0055;
        step("exfwd_b");
        check("exfwd.op0", op0_o[0], 16'h00AA);

        // Load-use on port 1, then MEM supplies the data.
        issue_load(4'd5);
        step("lu_load");
        clr_in();
        dec_valid_i = 1; dec_re1_i = 1; dec_addr1_i = 4'd5;
        #1;
        check("lu.stall_req", sreq_o[0], 1'b1);
        step("lu_bubble");
        check("lu.valid", valid_o[0], 1'b0);
        check("lu.cnt", cnt_a, 8'd1);
        mem_we_i = 1; mem_waddr_i = 4'd5; mem_wdata_i = 16'h1234;
        step("lu_mem");
        check("lu.op1", op1_o[0], 16'h1234);

        // Three stalled cycles with changing decode, then flush+stall together.
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b1);
            stall_i = 1; flush_i = 0;
            step("stall");
        end
        rand_in(1'b1);
        stall_i = 1; flush_i = 1;
        step("flush_stall");
        check("flush_stall.valid", valid_o[0], 1'b0);
        check("flush_stall.cnt", cnt_a, 8'd1);

        // r0 never forwarded or interlocked with ZERO_REG=1.
        issue_load(4'd0);
        step("zr_load");
        clr_in();
        dec_valid_i = 1; dec_re0_i = 1; dec_addr0_i = 4'd0; rf_data0_i = 16'hFFFF;
        ex_wdata_i = 16'hFFFF; mem_we_i = 1; mem_waddr_i = 4'd0; mem_wdata_i = 16'hFFFF;
        #1;
        check("zr.stall_req", sreq_o[1], 1'b0);
        step("zr_use");
        check("zr.op0", op0_o[1], 16'h0000);

        // Five back-to-back load-use bubbles saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            issue_load(4'd6);
            step("sat_load");
            clr_in();
            dec_valid_i = 1; dec_re0_i = 1; dec_addr0_i = 4'd6;
            step("sat_use");
        end
        check("sat.cnt", cnt_b, 2'd3);

        // Randomized traffic over a small register window to provoke hits.
        for (int i = 0; i < 400; i++) begin
            rand_in(i % 4 != 0);
            step("rand");
        end

        // Asynchronous reset while a stalled hazard is pending.
        issue_load(4'd7);
        step("ar_load");
        clr_in();
        dec_valid_i = 1; dec_re0_i = 1; dec_addr0_i = 4'd7; stall_i = 1;
        step("ar_stall");
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        check("async_rst.stall_req", sreq_o[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr_in();
        dec_valid_i = 1; dec_re1_i = 1; dec_addr1_i = 4'd7; rf_data1_i = 16'h0BEE;
        step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
